// File: rtl/ysyx_25060170_wb_arbiter_if.sv
// Writeback arbiter bus: EXU/LSU result handshakes, GPR write port and pending-write mask.
// Optional forwarding lookup signals exist only when WB_FWD_EN is defined.
interface ysyx_25060170_wb_arbiter_if;
    logic        exu_valid;
    logic        exu_ready;
    logic [4:0]  exu_rd;
    logic [31:0] exu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        GPR_we;
    logic [4:0]  GPR_writer;
    logic [31:0] GPR_wd;
    logic [31:0] pend_mask;
`ifdef WB_FWD_EN
    logic [4:0]  fwd_rs;
    logic        fwd_hit;
    logic [31:0] fwd_data;
`endif

    // Producers and decode-side consumers
    modport master (
        output exu_valid, exu_rd, exu_data,
        output lsu_valid, lsu_rd, lsu_data,
        input  exu_ready, lsu_ready,
        input  GPR_we, GPR_writer, GPR_wd, pend_mask
`ifdef WB_FWD_EN
        ,
        output fwd_rs,
        input  fwd_hit, fwd_data
`endif
    );

    modport slave (
        input  exu_valid, exu_rd, exu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        output exu_ready, lsu_ready,
        output GPR_we, GPR_writer, GPR_wd, pend_mask
`ifdef WB_FWD_EN
        ,
        input  fwd_rs,
        output fwd_hit, fwd_data
`endif
    );
endinterface

// File: rtl/ysyx_25060170_wb_arbiter.sv
// Writeback arbiter: buffers EXU/LSU results in a FIFO and drains one GPR write per cycle.
// Define WB_FWD_EN to add a combinational youngest-match forwarding lookup.
module ysyx_25060170_wb_arbiter #(
    parameter int DEPTH = 4
) (
    input logic                     clk,
    input logic                     rst,
    ysyx_25060170_wb_arbiter_if.slave wb
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [4:0]       rd_mem   [DEPTH];
    logic [31:0]      data_mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] space;
    logic             not_empty;
    logic             pop;
    logic             lsu_push;
    logic             exu_push;
    logic [1:0]       push_num;
    logic [DEPTH-1:0] slot_valid;
    logic [31:0]      pend_c;

    assign not_empty = (count != '0);
    assign pop       = not_empty;

    // The head always drains this cycle, so its slot counts as free for incoming results
    assign space        = CNT_W'(DEPTH) - count + CNT_W'(not_empty);
    assign wb.lsu_ready = (space >= CNT_W'(1));
    assign wb.exu_ready = (space >= CNT_W'(2)) || ((space == CNT_W'(1)) && !wb.lsu_valid);

    assign lsu_push = wb.lsu_valid && wb.lsu_ready && (wb.lsu_rd != 5'd0);
    assign exu_push = wb.exu_valid && wb.exu_ready && (wb.exu_rd != 5'd0);
    assign push_num = {1'b0, lsu_push} + {1'b0, exu_push};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(pop);
            tail  <= tail + PTR_W'(push_num);
            count <= count - CNT_W'(pop) + CNT_W'(push_num);
        end
    end

    // Storage needs no reset: only slots covered by count are ever observed
    always_ff @(posedge clk) begin
        if (lsu_push) begin
            rd_mem[tail]   <= wb.lsu_rd;
            data_mem[tail] <= wb.lsu_data;
        end
        if (exu_push) begin
            rd_mem[tail + PTR_W'(lsu_push)]   <= wb.exu_rd;
            data_mem[tail + PTR_W'(lsu_push)] <= wb.exu_data;
        end
    end

    assign wb.GPR_we     = not_empty;
    assign wb.GPR_writer = not_empty ? rd_mem[head]   : 5'd0;
    assign wb.GPR_wd     = not_empty ? data_mem[head] : 32'd0;

    always_comb begin
        slot_valid = '0;
        pend_c     = '0;
        for (int j = 0; j < DEPTH; j++) begin
            slot_valid[j] = ({1'b0, PTR_W'(PTR_W'(j) - head)} < count);
            if (slot_valid[j]) begin
                pend_c[rd_mem[j]] = 1'b1;
            end
        end
        pend_c[0] = 1'b0;
    end

    assign wb.pend_mask = pend_c;

`ifdef WB_FWD_EN
    logic [PTR_W-1:0] fwd_idx;
    logic             fwd_hit_c;
    logic [31:0]      fwd_data_c;

    // Walk oldest to youngest so the last match wins
    always_comb begin
        fwd_idx    = head;
        fwd_hit_c  = 1'b0;
        fwd_data_c = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head + PTR_W'(i);
            if ((CNT_W'(i) < count) && (wb.fwd_rs != 5'd0) && (rd_mem[fwd_idx] == wb.fwd_rs)) begin
                fwd_hit_c  = 1'b1;
                fwd_data_c = data_mem[fwd_idx];
            end
        end
    end

    assign wb.fwd_hit  = fwd_hit_c;
    assign wb.fwd_data = fwd_data_c;
`endif

endmodule

// File: tb/tb_ysyx_25060170_wb_arbiter.sv
// Scoreboard bench for ysyx_25060170_wb_arbiter; also checks forwarding when WB_FWD_EN is defined.
module tb_ysyx_25060170_wb_arbiter;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;
    logic [36:0] sb [$];

    always #5 clk = ~clk;

    ysyx_25060170_wb_arbiter_if bus();

    ysyx_25060170_wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (bus)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic logic [31:0] model_mask();
        logic [31:0] m = '0;
        foreach (sb[k]) m[sb[k][36:32]] = 1'b1;
        return m;
    endfunction

    // One cycle: drive, compare against the scoreboard, clock, then update the scoreboard
    task automatic applyStimulus(input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                                 input logic ev, input logic [4:0] erd, input logic [31:0] ed,
                                 output logic lacc, output logic eacc);
        int   space;
        logic exp_lr;
        logic exp_er;
`ifdef WB_FWD_EN
        logic        exp_hit;
        logic [31:0] exp_fd;
`endif
        bus.lsu_valid = lv;
        bus.lsu_rd    = lrd;
        bus.lsu_data  = ld;
        bus.exu_valid = ev;
        bus.exu_rd    = erd;
        bus.exu_data  = ed;
`ifdef WB_FWD_EN
        bus.fwd_rs = 5'($urandom_range(0, 31));
`endif
        #1;
        space  = DEPTH - sb.size() + ((sb.size() != 0) ? 1 : 0);
        exp_lr = (space >= 1);
        exp_er = (space >= 2) || ((space == 1) && !lv);
        checkOutput("lsu_ready", 32'(bus.lsu_ready), 32'(exp_lr));
        checkOutput("exu_ready", 32'(bus.exu_ready), 32'(exp_er));
        checkOutput("gpr_we", 32'(bus.GPR_we), 32'(sb.size() != 0));
        checkOutput("gpr_writer", 32'(bus.GPR_writer), (sb.size() != 0) ? 32'(sb[0][36:32]) : 32'd0);
        checkOutput("gpr_wd", bus.GPR_wd, (sb.size() != 0) ? sb[0][31:0] : 32'd0);
        checkOutput("pend_mask", bus.pend_mask, model_mask());
`ifdef WB_FWD_EN
        exp_hit = 1'b0;
        exp_fd  = 32'd0;
        if (bus.fwd_rs != 5'd0) begin
            foreach (sb[k]) begin
                if (sb[k][36:32] == bus.fwd_rs) begin
                    exp_hit = 1'b1;
                    exp_fd  = sb[k][31:0];
                end
            end
        end
        checkOutput("fwd_hit", 32'(bus.fwd_hit), 32'(exp_hit));
        checkOutput("fwd_data", bus.fwd_data, exp_fd);
`endif
        lacc = lv && exp_lr;
        eacc = ev && exp_er;
        @(posedge clk);
        if (sb.size() != 0) void'(sb.pop_front());
        if (lacc && (lrd != 5'd0)) sb.push_back({lrd, ld});
        if (eacc && (erd != 5'd0)) sb.push_back({erd, ed});
        @(negedge clk);
    endtask

    task automatic idle_cycles(input int n);
        logic la, ea;
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, la, ea);
    endtask

    task automatic drain();
        logic la, ea;
        for (int i = 0; i < 20 && sb.size() != 0; i++) applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, la, ea);
        checkOutput("drain_empty", 32'(sb.size()), 32'd0);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, la, ea);
    endtask

    // Both producers hold a result until it is accepted; random mode mixes idle gaps and rd=0
    task automatic run_traffic(input int cycles, input bit random_mode, output bit exu_stalled);
        logic        l_pend = 1'b0, e_pend = 1'b0;
        logic [4:0]  l_rd = '0, e_rd = '0;
        logic [31:0] l_d = '0, e_d = '0;
        logic        la, ea;
        int          seq = 0;
        exu_stalled = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            if (!l_pend) begin
                l_pend = random_mode ? 1'($urandom_range(0, 1)) : 1'b1;
                l_rd   = random_mode ? (($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31)))
                                     : 5'((seq % 31) + 1);
                l_d    = $urandom();
                seq++;
            end
            if (!e_pend) begin
                e_pend = random_mode ? 1'($urandom_range(0, 1)) : 1'b1;
                e_rd   = random_mode ? (($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31)))
                                     : 5'((seq % 31) + 1);
                e_d    = $urandom();
                seq++;
            end
            applyStimulus(l_pend, l_rd, l_d, e_pend, e_rd, e_d, la, ea);
            if (e_pend && !ea) exu_stalled = 1'b1;
            if (la) l_pend = 1'b0;
            if (ea) e_pend = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic la, ea;
        bit   stalled;
        bus.lsu_valid = 1'b0;
        bus.lsu_rd    = '0;
        bus.lsu_data  = '0;
        bus.exu_valid = 1'b0;
        bus.exu_rd    = '0;
        bus.exu_data  = '0;
`ifdef WB_FWD_EN
        bus.fwd_rs = '0;
`endif
        #1;
        checkOutput("rst_we", 32'(bus.GPR_we), 32'd0);
        checkOutput("rst_writer", 32'(bus.GPR_writer), 32'd0);
        checkOutput("rst_wd", bus.GPR_wd, 32'd0);
        checkOutput("rst_mask", bus.pend_mask, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        idle_cycles(1);

        $display("[TB] single EXU write");
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h0000_1234, la, ea);
        bus.exu_valid = 1'b0;
        #1;
        checkOutput("t1_we", 32'(bus.GPR_we), 32'd1);
        checkOutput("t1_writer", 32'(bus.GPR_writer), 32'd5);
        checkOutput("t1_wd", bus.GPR_wd, 32'h0000_1234);
        checkOutput("t1_mask", bus.pend_mask, 32'h0000_0020);
        idle_cycles(1);
        checkOutput("t1_mask_after", bus.pend_mask, 32'd0);
        checkOutput("t1_we_after", 32'(bus.GPR_we), 32'd0);

        $display("[TB] dual accept ordering");
        applyStimulus(1'b1, 5'd3, 32'hA, 1'b1, 5'd4, 32'hB, la, ea);
        bus.lsu_valid = 1'b0;
        bus.exu_valid = 1'b0;
        #1;
        checkOutput("t2_writer1", 32'(bus.GPR_writer), 32'd3);
        checkOutput("t2_mask1", bus.pend_mask, 32'h18);
        idle_cycles(1);
        #1;
        checkOutput("t2_writer2", 32'(bus.GPR_writer), 32'd4);
        checkOutput("t2_mask2", bus.pend_mask, 32'h10);
        drain();

        $display("[TB] sustained dual traffic");
        run_traffic(20, 1'b0, stalled);
        checkOutput("t3_exu_stall_seen", 32'(stalled), 32'd1);
        drain();

        $display("[TB] rd zero discarded");
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, la, ea);
        checkOutput("t4_exu_acc", 32'(ea), 32'd1);
        idle_cycles(2);

        $display("[TB] same rd from both sources");
        applyStimulus(1'b1, 5'd9, 32'h99, 1'b1, 5'd9, 32'h77, la, ea);
        drain();

        $display("[TB] random traffic");
        run_traffic(60, 1'b1, stalled);
        drain();

`ifdef WB_FWD_EN
        $display("[TB] forwarding youngest match");
        applyStimulus(1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 32'h22, la, ea);
        bus.lsu_valid = 1'b0;
        bus.exu_valid = 1'b0;
        bus.fwd_rs    = 5'd7;
        #1;
        checkOutput("t6_hit", 32'(bus.fwd_hit), 32'd1);
        checkOutput("t6_data", bus.fwd_data, 32'h22);
        bus.fwd_rs = 5'd0;
        #1;
        checkOutput("t6_hit_x0", 32'(bus.fwd_hit), 32'd0);
        checkOutput("t6_data_x0", bus.fwd_data, 32'd0);
        drain();
`endif

        $display("[TB] reset with pending entries");
        applyStimulus(1'b1, 5'd1, 32'h101, 1'b1, 5'd2, 32'h202, la, ea);
        applyStimulus(1'b1, 5'd3, 32'h303, 1'b1, 5'd6, 32'h606, la, ea);
        bus.lsu_valid = 1'b0;
        bus.exu_valid = 1'b0;
        checkOutput("t5_pending", 32'(sb.size()), 32'd3);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("t5_we", 32'(bus.GPR_we), 32'd0);
        checkOutput("t5_writer", 32'(bus.GPR_writer), 32'd0);
        checkOutput("t5_wd", bus.GPR_wd, 32'd0);
        checkOutput("t5_mask", bus.pend_mask, 32'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        idle_cycles(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
